// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/LSU memory port arbiter.
// Imported by the arbiter top, its grant sub-module and the bench.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_t;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam logic [3:0] BE_WORD = 4'hF;

  // A zero-cycle watchdog still needs a 1-bit counter to elaborate.
  function automatic int timer_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port A, LSU port B and memory slave signals of the arbiter.
// slave: arbiter view; master: view of the core plus memory around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                  a_valid_i;
  logic [ADDR_WIDTH-1:0] a_addr_i;
  logic                  a_ready_o;
  logic [DATA_WIDTH-1:0] a_rdata_o;
  logic                  a_err_o;

  logic                  b_valid_i;
  logic                  b_we_i;
  logic [3:0]            b_be_i;
  logic [ADDR_WIDTH-1:0] b_addr_i;
  logic [DATA_WIDTH-1:0] b_wdata_i;
  logic                  b_ready_o;
  logic [DATA_WIDTH-1:0] b_rdata_o;
  logic                  b_err_o;

  logic                  s_valid_o;
  logic                  s_we_o;
  logic [3:0]            s_be_o;
  logic [ADDR_WIDTH-1:0] s_addr_o;
  logic [DATA_WIDTH-1:0] s_wdata_o;
  logic                  s_ready_i;
  logic [DATA_WIDTH-1:0] s_rdata_i;

  modport slave (
    input  a_valid_i, a_addr_i,
    output a_ready_o, a_rdata_o, a_err_o,
    input  b_valid_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
    output b_ready_o, b_rdata_o, b_err_o,
    output s_valid_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
    input  s_ready_i, s_rdata_i
  );

  modport master (
    output a_valid_i, a_addr_i,
    input  a_ready_o, a_rdata_o, a_err_o,
    output b_valid_i, b_we_i, b_be_i, b_addr_i, b_wdata_i,
    input  b_ready_o, b_rdata_o, b_err_o,
    input  s_valid_o, s_we_o, s_be_o, s_addr_o, s_wdata_o,
    output s_ready_i, s_rdata_i
  );

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Combinational 2-way grant: round-robin on last_grant or fixed A-first.
// Only meaningful while any is high.
module arb_rr2
  import mem_port_arbiter_pkg::*;
#(
  parameter int MODE = ARB_RR
) (
  input  logic   a_valid,
  input  logic   b_valid,
  input  grant_t last_grant,
  output logic   any,
  output grant_t gnt
);

  always_comb begin
    any = a_valid | b_valid;
    gnt = GNT_A;
    unique case (1'b1)
      (a_valid && !b_valid): gnt = GNT_A;
      (b_valid && !a_valid): gnt = GNT_B;
      (a_valid && b_valid): begin
        if (MODE == ARB_FIXED)
          gnt = GNT_A;
        else if (last_grant == GNT_A)
          gnt = GNT_B;
        else
          gnt = GNT_A;
      end
      default: gnt = GNT_A;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch (A) and load/store (B),
// one transaction in flight, with an optional response watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = ARB_RR,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                clk,
  input logic                rst_i,
  mem_port_arbiter_if.slave  bus
);

  localparam int TW = timer_width(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
  localparam int T_LAST_I = WD_EN ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [TW-1:0] T_LAST = TW'(T_LAST_I);

  state_t        state;
  grant_t        grant;
  grant_t        last_grant;
  grant_t        win;
  logic          any;
  logic [TW-1:0] timer;

  arb_rr2 #(
    .MODE (ARB_MODE)
  ) u_arb (
    .a_valid    (bus.a_valid_i),
    .b_valid    (bus.b_valid_i),
    .last_grant (last_grant),
    .any        (any),
    .gnt        (win)
  );

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      grant         <= GNT_A;
      last_grant    <= GNT_B;
      timer         <= '0;
      bus.a_ready_o <= 1'b0;
      bus.a_rdata_o <= '0;
      bus.a_err_o   <= 1'b0;
      bus.b_ready_o <= 1'b0;
      bus.b_rdata_o <= '0;
      bus.b_err_o   <= 1'b0;
      bus.s_valid_o <= 1'b0;
      bus.s_we_o    <= 1'b0;
      bus.s_be_o    <= '0;
      bus.s_addr_o  <= '0;
      bus.s_wdata_o <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            grant         <= win;
            bus.s_valid_o <= 1'b1;
            state         <= ST_ISSUE;
            if (win == GNT_A) begin
              bus.s_we_o    <= 1'b0;
              bus.s_be_o    <= BE_WORD;
              bus.s_addr_o  <= bus.a_addr_i;
              bus.s_wdata_o <= '0;
            end else begin
              bus.s_we_o    <= bus.b_we_i;
              bus.s_be_o    <= bus.b_be_i;
              bus.s_addr_o  <= bus.b_addr_i;
              bus.s_wdata_o <= bus.b_wdata_i;
            end
          end
        end
        ST_ISSUE: begin
          bus.s_valid_o <= 1'b0;
          timer         <= '0;
          state         <= ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.s_ready_i) begin
            if (grant == GNT_A) begin
              bus.a_rdata_o <= bus.s_rdata_i;
              bus.a_ready_o <= 1'b1;
            end else begin
              bus.b_rdata_o <= bus.s_rdata_i;
              bus.b_ready_o <= 1'b1;
            end
            state <= ST_RESP;
          end else if (WD_EN && timer == T_LAST) begin
            if (grant == GNT_A) begin
              bus.a_rdata_o <= '0;
              bus.a_ready_o <= 1'b1;
              bus.a_err_o   <= 1'b1;
            end else begin
              bus.b_rdata_o <= '0;
              bus.b_ready_o <= 1'b1;
              bus.b_err_o   <= 1'b1;
            end
            state <= ST_RESP;
          end else if (timer != '1) begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: begin
          bus.a_ready_o <= 1'b0;
          bus.a_err_o   <= 1'b0;
          bus.b_ready_o <= 1'b0;
          bus.b_err_o   <= 1'b0;
          last_grant    <= grant;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, corner sequences,
// and random traffic against a transaction-level reference.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m ();
  mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mf ();

  mem_port_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .ARB_MODE       (ARB_RR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (m)
  );

  mem_port_arbiter #(
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .ARB_MODE       (ARB_FIXED),
    .TIMEOUT_CYCLES (TO)
  ) dut_fx (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (mf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory for the round-robin DUT: 1-cycle latency, clears on reset
  logic [31:0] ram [0:127];
  logic        mem_en;
  logic        inj;
  logic [31:0] inj_data;

  always @(posedge clk) begin
    m.s_ready_i <= 1'b0;
    if (rst_i) begin
      for (int i = 0; i < 128; i++) ram[i] <= '0;
    end else if (inj) begin
      m.s_ready_i <= 1'b1;
      m.s_rdata_i <= inj_data;
    end else if (mem_en && m.s_valid_o) begin
      m.s_ready_i <= 1'b1;
      if (m.s_we_o) begin
        for (int k = 0; k < 4; k++)
          if (m.s_be_o[k])
            ram[m.s_addr_o[8:2]][8*k+:8] <= m.s_wdata_o[8*k+:8];
        m.s_rdata_i <= '0;
      end else begin
        m.s_rdata_i <= ram[m.s_addr_o[8:2]];
      end
    end
  end

  always @(posedge clk) begin
    mf.s_ready_i <= mf.s_valid_o;
    mf.s_rdata_i <= mf.s_addr_o ^ 32'h5A5A_0000;
  end

  typedef struct {
    bit          port_b;
    bit          we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [11];

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    m.a_valid_i = 1'b0;
    m.b_valid_i = 1'b0;
    mf.a_valid_i = 1'b0;
    mf.b_valid_i = 1'b0;
    inj = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    int pulses;
    @(negedge clk);
    if (v.port_b) begin
      m.b_valid_i = 1'b1;
      m.b_we_i    = v.we;
      m.b_be_i    = v.be;
      m.b_addr_i  = v.addr;
      m.b_wdata_i = v.wdata;
    end else begin
      m.a_valid_i = 1'b1;
      m.a_addr_i  = v.addr;
    end
    @(negedge clk);
    check("issue_cycle1", m.s_valid_o, 1);
    check("s_we", m.s_we_o, v.exp_we);
    check("s_be", m.s_be_o, v.exp_be);
    check("s_addr", m.s_addr_o, v.addr);
    check("s_wdata", m.s_wdata_o, v.exp_wdata);
    lat = 99;
    pulses = 0;
    for (int c = 2; c <= 40; c++) begin
      @(negedge clk);
      if (m.s_valid_o) pulses++;
      if (v.port_b ? m.b_ready_o : m.a_ready_o) begin
        lat = c;
        break;
      end
    end
    check("resp_latency", lat, 3);
    check("extra_issue", pulses, 0);
    check("rdata", v.port_b ? m.b_rdata_o : m.a_rdata_o, v.exp_rdata);
    check("err", v.port_b ? m.b_err_o : m.a_err_o, 0);
    check("other_ready", v.port_b ? m.a_ready_o : m.b_ready_o, 0);
    m.a_valid_i = 1'b0;
    m.b_valid_i = 1'b0;
  endtask

  task automatic count_ready(input int n, output int cnt);
    cnt = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (m.a_ready_o || m.b_ready_o) cnt++;
    end
  endtask

  typedef struct {
    logic        v;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t        ra, rb, r;
  bit          pa_prev, pb_prev, last_b, outst, out_b, wb;
  logic [31:0] exp_rd;
  logic [31:0] sh [0:127];
  int          issue_cyc, idx, cnt, lat, nord;
  bit          ord [8];

  initial begin
    m.a_valid_i = 0; m.a_addr_i = 0;
    m.b_valid_i = 0; m.b_we_i = 0; m.b_be_i = 0;
    m.b_addr_i = 0; m.b_wdata_i = 0;
    mf.a_valid_i = 0; mf.a_addr_i = 0;
    mf.b_valid_i = 0; mf.b_we_i = 0; mf.b_be_i = 0;
    mf.b_addr_i = 0; mf.b_wdata_i = 0;
    mem_en = 1'b1;
    inj = 1'b0;
    inj_data = '0;

    tbl[0]  = '{1, 1, 4'hF, 32'h10, 32'hDEADBEEF, 1, 4'hF, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{0, 0, 4'h0, 32'h10, 32'h0, 0, 4'hF, 32'h0, 32'hDEADBEEF};
    tbl[2]  = '{1, 1, 4'h3, 32'h20, 32'h1234ABCD, 1, 4'h3, 32'h1234ABCD, 32'h0};
    tbl[3]  = '{1, 0, 4'h5, 32'h20, 32'h77777777, 0, 4'h5, 32'h77777777, 32'h0000ABCD};
    tbl[4]  = '{0, 0, 4'h0, 32'h20, 32'h0, 0, 4'hF, 32'h0, 32'h0000ABCD};
    tbl[5]  = '{1, 1, 4'hC, 32'h24, 32'hCAFEF00D, 1, 4'hC, 32'hCAFEF00D, 32'h0};
    tbl[6]  = '{0, 0, 4'h0, 32'h24, 32'h0, 0, 4'hF, 32'h0, 32'hCAFE0000};
    tbl[7]  = '{1, 0, 4'hF, 32'h10, 32'h0, 0, 4'hF, 32'h0, 32'hDEADBEEF};
    tbl[8]  = '{1, 1, 4'hF, 32'h30, 32'hFFFFFFFF, 1, 4'hF, 32'hFFFFFFFF, 32'h0};
    tbl[9]  = '{1, 0, 4'hF, 32'h30, 32'h0, 0, 4'hF, 32'h0, 32'hFFFFFFFF};
    tbl[10] = '{0, 0, 4'h0, 32'h30, 32'h0, 0, 4'hF, 32'h0, 32'hFFFFFFFF};

    @(negedge clk);
    @(negedge clk);
    check("rst_a_ready", m.a_ready_o, 0);
    check("rst_b_ready", m.b_ready_o, 0);
    check("rst_s_valid", m.s_valid_o, 0);
    check("rst_s_be", m.s_be_o, 0);
    check("rst_a_rdata", m.a_rdata_o, 0);
    rst_i = 1'b0;

    // Single transactions, table driven (A read 0x10, B byte writes)
    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // Both ports held from reset: RR alternates A,B,A,B
    do_reset();
    @(negedge clk);
    m.a_valid_i = 1; m.a_addr_i = 32'h40;
    m.b_valid_i = 1; m.b_we_i = 0; m.b_be_i = 4'hF; m.b_addr_i = 32'h44;
    nord = 0;
    for (int c = 0; c < 40 && nord < 4; c++) begin
      @(negedge clk);
      if (m.a_ready_o) begin ord[nord] = 0; nord++; end
      if (m.b_ready_o) begin ord[nord] = 1; nord++; end
    end
    check("rr_count", nord, 4);
    check("rr_g0", ord[0], 0);
    check("rr_g1", ord[1], 1);
    check("rr_g2", ord[2], 0);
    check("rr_g3", ord[3], 1);
    m.a_valid_i = 0;
    m.b_valid_i = 0;

    // Fixed priority: A wins every time until it drops
    do_reset();
    @(negedge clk);
    mf.a_valid_i = 1; mf.a_addr_i = 32'h40;
    mf.b_valid_i = 1; mf.b_we_i = 0; mf.b_be_i = 4'hF; mf.b_addr_i = 32'h44;
    nord = 0;
    for (int c = 0; c < 60 && nord < 4; c++) begin
      @(negedge clk);
      if (mf.a_ready_o) begin ord[nord] = 0; nord++; end
      if (mf.b_ready_o) begin
        ord[nord] = 1; nord++;
        check("fx_b_rdata", mf.b_rdata_o, 32'h5A5A_0044);
      end
      if (nord == 3) mf.a_valid_i = 0;
    end
    check("fx_count", nord, 4);
    check("fx_g0", ord[0], 0);
    check("fx_g1", ord[1], 0);
    check("fx_g2", ord[2], 0);
    check("fx_g3", ord[3], 1);
    mf.b_valid_i = 0;

    // Watchdog: silent memory, response with error at cycle 18
    do_reset();
    run_vec(tbl[8]);
    run_vec(tbl[9]);
    @(negedge clk);
    mem_en = 1'b0;
    m.b_valid_i = 1; m.b_we_i = 0; m.b_addr_i = 32'h30;
    lat = 99;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (m.b_ready_o) begin lat = c; break; end
    end
    check("to_latency", lat, 18);
    check("to_err", m.b_err_o, 1);
    check("to_rdata", m.b_rdata_o, 0);
    check("to_a_ready", m.a_ready_o, 0);
    m.b_valid_i = 0;
    @(negedge clk);
    check("to_err_pulse", m.b_err_o, 0);
    inj = 1; inj_data = 32'h12345678;
    @(negedge clk);
    inj = 0;
    count_ready(6, cnt);
    check("to_late_ignored", cnt, 0);

    // Reset in WAIT clears outputs at once, no response afterwards
    mem_en = 1'b1;
    run_vec(tbl[10]);
    mem_en = 1'b0;
    @(negedge clk);
    m.a_valid_i = 1; m.a_addr_i = 32'h34;
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("mid_rst_a_rdata", m.a_rdata_o, 0);
    check("mid_rst_s_addr", m.s_addr_o, 0);
    check("mid_rst_s_be", m.s_be_o, 0);
    check("mid_rst_a_ready", m.a_ready_o, 0);
    m.a_valid_i = 0;
    @(negedge clk);
    rst_i = 1'b0;
    inj = 1; inj_data = 32'h11111111;
    @(negedge clk);
    inj = 0;
    count_ready(6, cnt);
    check("mid_rst_no_resp", cnt, 0);

    // B changes its request during WAIT: latched fields, one issue pulse
    @(negedge clk);
    m.b_valid_i = 1; m.b_we_i = 0; m.b_be_i = 4'hF; m.b_addr_i = 32'h50;
    cnt = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (m.s_valid_o) cnt++;
      if (c == 2) begin
        m.b_addr_i = 32'h54;
        m.b_we_i = 1;
      end
    end
    check("chg_s_addr", m.s_addr_o, 32'h50);
    check("chg_s_we", m.s_we_o, 0);
    inj = 1; inj_data = 32'h600DF00D;
    lat = 99;
    for (int c = 6; c <= 20; c++) begin
      @(negedge clk);
      inj = 0;
      if (m.s_valid_o) cnt++;
      if (m.b_ready_o) begin lat = c; break; end
    end
    check("chg_latency", lat, 7);
    check("chg_rdata", m.b_rdata_o, 32'h600DF00D);
    check("chg_issue_pulses", cnt, 1);
    m.b_valid_i = 0;

    // Random traffic against a transaction-level reference
    do_reset();
    mem_en = 1'b1;
    for (int i = 0; i < 128; i++) sh[i] = '0;
    ra = '{default: '0};
    rb = '{default: '0};
    pa_prev = 0; pb_prev = 0; last_b = 1; outst = 0; out_b = 0;
    exp_rd = '0; issue_cyc = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      if (m.s_valid_o) begin
        check("rnd_issue_pending", pa_prev | pb_prev, 1);
        check("rnd_issue_idle", outst, 0);
        wb = (pa_prev && pb_prev) ? !last_b : pb_prev;
        r = wb ? rb : ra;
        check("rnd_s_addr", m.s_addr_o, r.addr);
        check("rnd_s_we", m.s_we_o, wb ? r.we : 1'b0);
        check("rnd_s_be", m.s_be_o, wb ? r.be : 4'hF);
        check("rnd_s_wdata", m.s_wdata_o, wb ? r.wdata : 32'h0);
        idx = int'(r.addr[8:2]);
        if (wb && r.we) begin
          for (int k = 0; k < 4; k++)
            if (r.be[k]) sh[idx][8*k+:8] = r.wdata[8*k+:8];
          exp_rd = '0;
        end else begin
          exp_rd = sh[idx];
        end
        last_b = wb; out_b = wb; outst = 1; issue_cyc = cyc;
      end
      if (m.a_ready_o || m.b_ready_o) begin
        check("rnd_outstanding", outst, 1);
        check("rnd_port", m.b_ready_o, out_b);
        check("rnd_one_port", m.a_ready_o & m.b_ready_o, 0);
        check("rnd_rdata", out_b ? m.b_rdata_o : m.a_rdata_o, exp_rd);
        check("rnd_err", m.a_err_o | m.b_err_o, 0);
        check("rnd_latency", cyc - issue_cyc, 2);
        if (out_b) rb.v = 0;
        else ra.v = 0;
        outst = 0;
      end
      if (!ra.v && $urandom_range(2) == 0) begin
        ra.v = 1;
        ra.addr = {25'h0, 3'($urandom_range(7)), 4'h0} | 32'(4 * $urandom_range(3));
      end
      if (!rb.v && $urandom_range(2) == 0) begin
        rb.v = 1;
        rb.we = 1'($urandom_range(1));
        rb.be = 4'($urandom_range(15));
        rb.wdata = $urandom;
        rb.addr = {25'h0, 3'($urandom_range(7)), 4'h0} | 32'(4 * $urandom_range(3));
      end
      m.a_valid_i = ra.v; m.a_addr_i = ra.addr;
      m.b_valid_i = rb.v; m.b_we_i = rb.we; m.b_be_i = rb.be;
      m.b_addr_i = rb.addr; m.b_wdata_i = rb.wdata;
      pa_prev = ra.v;
      pb_prev = rb.v;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
